// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and round datapath.
// Holds mode encodings, last-round indices, the Rcon seed, the key-schedule
// FSM state type and small GF(2^8)/word helpers.
package aes_pkg;

  localparam logic MODE_128 = 1'b0;
  localparam logic MODE_256 = 1'b1;

  localparam logic [3:0] LAST_ROUND_128 = 4'd10;
  localparam logic [3:0] LAST_ROUND_256 = 4'd14;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ke_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // RotWord({a,b,c,d}) = {b,c,d,a}
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational, one byte wide.
// Ports:
//   in_byte  - byte to substitute
//   out_byte - S-box(in_byte)
// Shared by the key schedule (SubWord) and the SubBytes stage.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  always_comb begin
    out_byte = SBOX[in_byte];
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128/AES-256 key schedule. Presents one 128-bit round key at
// a time to the AddRoundKey stage and advances on each valid/ready handshake.
// Ports:
//   clk, rst_n        - clock (rising edge), async active-low reset
//   start, mode       - load key_in in IDLE; mode 0 = AES-128, 1 = AES-256
//   key_in[255:0]     - cipher key, w0 = key_in[255:224] ... w7 = key_in[31:0]
//   ready             - high in IDLE (a start will be accepted)
//   rk_valid/rk_ready - round-key handshake
//   rk0..rk3          - round key words 0..3 (AddRoundKey key0..key3)
//   rk_round          - index of the presented round key
//   done              - one-cycle pulse after the last round key is accepted
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [255:0] key_in,
  output logic         ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [31:0]  rk0,
  output logic [31:0]  rk1,
  output logic [31:0]  rk2,
  output logic [31:0]  rk3,
  output logic [3:0]   rk_round,
  output logic         done
);

  ke_state_e state_q, state_d;

  // Word [0] of each register is the round key's word 0.
  logic [3:0][31:0] cur_q,  cur_d;
  logic [3:0][31:0] prev_q, prev_d;
  logic [3:0][31:0] hi_q,   hi_d;

  logic       mode_q,  mode_d;
  logic [7:0] rcon_q,  rcon_d;
  logic [3:0] round_q, round_d;
  logic       valid_q, valid_d;
  logic       done_q,  done_d;

  logic [3:0]       target_round;
  logic [3:0]       last_round;
  logic             handshake;
  logic             from_hi;
  logic             use_rot;
  logic [31:0]      sbox_in;
  logic [31:0]      sub_word;
  logic [31:0]      t_word;
  logic [3:0][31:0] base_key;
  logic [3:0][31:0] next_key;
  logic [7:0]       rcon_next;

  assign target_round = round_q + 4'd1;
  assign last_round   = (mode_q == MODE_256) ? LAST_ROUND_256 : LAST_ROUND_128;
  assign handshake    = valid_q & rk_ready;

  // AES-256 round 1 is the upper key half verbatim. Otherwise odd AES-256
  // rounds take SubWord without RotWord/Rcon; all other steps take both.
  assign from_hi = (mode_q == MODE_256) && (round_q == 4'd0);
  assign use_rot = (mode_q == MODE_128) || !target_round[0];
  assign sbox_in = use_rot ? rot_word(cur_q[3]) : cur_q[3];

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (sbox_in[8*b +: 8]),
      .out_byte (sub_word[8*b +: 8])
    );
  end

  assign t_word    = sub_word ^ (use_rot ? {rcon_q, 24'h000000} : 32'h0);
  assign rcon_next = (use_rot && !from_hi) ? xtime(rcon_q) : rcon_q;

  // AES-128 chains from the presented key; AES-256 chains from the key two
  // steps back, which is the previously presented one.
  always_comb begin
    base_key = (mode_q == MODE_256) ? prev_q : cur_q;
    next_key = '0;
    if (from_hi) begin
      next_key = hi_q;
    end else begin
      next_key[0] = base_key[0] ^ t_word;
      next_key[1] = next_key[0] ^ base_key[1];
      next_key[2] = next_key[1] ^ base_key[2];
      next_key[3] = next_key[2] ^ base_key[3];
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    hi_d    = hi_q;
    mode_d  = mode_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          valid_d = 1'b1;
          round_d = 4'd0;
          mode_d  = mode;
          rcon_d  = RCON_INIT;
          prev_d  = '0;
          for (int unsigned i = 0; i < 4; i++) begin
            cur_d[i] = key_in[255 - 32*i -: 32];
            hi_d[i]  = key_in[127 - 32*i -: 32];
          end
        end
      end
      ST_RUN: begin
        if (handshake) begin
          prev_d = cur_q;
          if (round_q == last_round) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            round_d = target_round;
            cur_d   = next_key;
            rcon_d  = rcon_next;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      prev_q  <= '0;
      hi_q    <= '0;
      mode_q  <= MODE_128;
      rcon_q  <= RCON_INIT;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign rk_valid = valid_q;
  assign rk0      = cur_q[0];
  assign rk1      = cur_q[1];
  assign rk2      = cur_q[2];
  assign rk3      = cur_q[3];
  assign rk_round = round_q;
  assign done     = done_q;

endmodule
